// File: rtl/slot_alloc.sv
// Slot allocator: offers the first free slot in a W-entry pool (LSB- or MSB-first),
// tracks busy slots and their count, and flags releases of slots that are not held.
module slot_alloc #(
    parameter int W        = 16,
    parameter bit FROM_LSB = 1'b1
) (
    input  logic                   clk,
    input  logic                   arst,
    output logic                   o_alloc_vld,
    output logic [$clog2(W)-1:0]   o_alloc_id,
    input  logic                   i_alloc_rdy,
    input  logic                   i_free_vld,
    input  logic [$clog2(W)-1:0]   i_free_id,
    input  logic                   i_flush,
    output logic [W-1:0]           o_busy,
    output logic [$clog2(W+1)-1:0] o_cnt,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_free_err
);

    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W+1);
    localparam logic [IW:0] W_L = (IW+1)'(W);

    logic [W-1:0]  busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [W-1:0]  sel_oh;
    logic [IW-1:0] sel_id;
    logic          found;
    logic          alloc_vld;
    logic          alloc_acc;
    logic          free_ok;
    logic          free_bad;

    // First-zero detector on the busy vector, then one-hot to index.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        sel_oh = '0;
        sel_id = '0;
        found  = 1'b0;
        if (FROM_LSB) begin
            for (int i = 0; i < W; i++) begin
                if (!found && !busy_q[i]) begin
                    sel_oh[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end else begin
            for (int i = W-1; i >= 0; i--) begin
                if (!found && !busy_q[i]) begin
                    sel_oh[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        for (int i = 0; i < W; i++) begin
            if (sel_oh[i]) sel_id = sel_id | IW'(i);
        end
    end

    assign alloc_vld = ~&busy_q;
    assign alloc_acc = alloc_vld & i_alloc_rdy;
    assign free_ok   = i_free_vld & ({1'b0, i_free_id} < W_L) & busy_q[i_free_id];
    assign free_bad  = i_free_vld & ~free_ok;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        if (i_flush) begin
            // Flush wins: the concurrent grant and release are dropped, no error raised.
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (alloc_acc) busy_d = busy_d | sel_oh;
            if (free_ok)   busy_d = busy_d & ~(W'(1) << i_free_id);
            unique case ({alloc_acc, free_ok})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            err_d = free_bad;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign o_alloc_vld = alloc_vld;
    assign o_alloc_id  = alloc_vld ? sel_id : '0;
    assign o_busy      = busy_q;
    assign o_cnt       = cnt_q;
    assign o_full      = (cnt_q == CW'(W));
    assign o_empty     = (cnt_q == '0);
    assign o_free_err  = err_q;

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc: W=4 LSB-first and MSB-first instances share stimulus;
// expected output snapshots go through a scoreboard queue and are compared after each edge.
module tb_slot_alloc;

    typedef struct packed {
        logic       vld;
        logic [1:0] id;
        logic [3:0] busy;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } snap_t;

    logic       clk = 1'b0;
    logic       arst;
    logic       i_alloc_rdy, i_free_vld, i_flush;
    logic [1:0] i_free_id;

    logic       vld0, vld1, full0, full1, empty0, empty1, err0, err1;
    logic [1:0] id0, id1;
    logic [3:0] busy0, busy1;
    logic [2:0] cnt0, cnt1;

    snap_t obs0, obs1;
    snap_t sb_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    slot_alloc #(.W(4), .FROM_LSB(1'b1)) dut_lsb (
        .clk(clk), .arst(arst),
        .o_alloc_vld(vld0), .o_alloc_id(id0), .i_alloc_rdy(i_alloc_rdy),
        .i_free_vld(i_free_vld), .i_free_id(i_free_id), .i_flush(i_flush),
        .o_busy(busy0), .o_cnt(cnt0), .o_full(full0), .o_empty(empty0), .o_free_err(err0)
    );

    slot_alloc #(.W(4), .FROM_LSB(1'b0)) dut_msb (
        .clk(clk), .arst(arst),
        .o_alloc_vld(vld1), .o_alloc_id(id1), .i_alloc_rdy(i_alloc_rdy),
        .i_free_vld(i_free_vld), .i_free_id(i_free_id), .i_flush(i_flush),
        .o_busy(busy1), .o_cnt(cnt1), .o_full(full1), .o_empty(empty1), .o_free_err(err1)
    );

    assign obs0 = {vld0, id0, busy0, cnt0, full0, empty0, err0};
    assign obs1 = {vld1, id1, busy1, cnt1, full1, empty1, err1};

    function automatic snap_t mk(logic vld, logic [1:0] id, logic [3:0] busy,
                                 logic [2:0] cnt, logic err);
        snap_t s;
        s.vld   = vld;
        s.id    = id;
        s.busy  = busy;
        s.cnt   = cnt;
        s.full  = (cnt == 3'd4);
        s.empty = (cnt == 3'd0);
        s.err   = err;
        return s;
    endfunction

    task automatic drive(logic rdy, logic fv, logic [1:0] fid, logic fl);
        i_alloc_rdy = rdy;
        i_free_vld  = fv;
        i_free_id   = fid;
        i_flush     = fl;
    endtask

    // Pops the oldest expectation and compares it with the chosen instance's outputs.
    task automatic compare(string tag, int which);
        snap_t e;
        snap_t o;
        e = sb_q.pop_front();
        o = (which == 0) ? obs0 : obs1;
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed vld=%b id=%0d busy=%b cnt=%0d full=%b empty=%b err=%b, expected vld=%b id=%0d busy=%b cnt=%0d full=%b empty=%b err=%b",
                   tag, o.vld, o.id, o.busy, o.cnt, o.full, o.empty, o.err,
                   e.vld, e.id, e.busy, e.cnt, e.full, e.empty, e.err);
        end
    endtask

    task automatic expect_now(string tag, int which, snap_t e);
        sb_q.push_back(e);
        compare(tag, which);
    endtask

    task automatic expect_next(string tag, int which, snap_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag, which);
    endtask

    initial begin
        arst = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        #3;
        expect_now("reset_lsb", 0, mk(1, 2'd0, 4'b0000, 3'd0, 0));
        expect_now("reset_msb", 1, mk(1, 2'd3, 4'b0000, 3'd0, 0));
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Fill: four grants, then a fifth ready cycle with nothing to offer.
        drive(1'b1, 1'b0, 2'd0, 1'b0);
        expect_next("fill_0", 0, mk(1, 2'd1, 4'b0001, 3'd1, 0));
        expect_next("fill_1", 0, mk(1, 2'd2, 4'b0011, 3'd2, 0));
        expect_next("fill_2", 0, mk(1, 2'd3, 4'b0111, 3'd3, 0));
        expect_next("fill_3", 0, mk(0, 2'd0, 4'b1111, 3'd4, 0));
        expect_next("fill_5th_idle", 0, mk(0, 2'd0, 4'b1111, 3'd4, 0));

        // Release from full; the freed slot must not be offered in the free cycle.
        drive(1'b1, 1'b1, 2'd2, 1'b0);
        #1;
        expect_now("free_cycle_no_bypass", 0, mk(0, 2'd0, 4'b1111, 3'd4, 0));
        expect_next("reuse_id2", 0, mk(1, 2'd2, 4'b1011, 3'd3, 0));

        drive(1'b0, 1'b1, 2'd3, 1'b0);
        expect_next("free_id3", 0, mk(1, 2'd2, 4'b0011, 3'd2, 0));

        // Simultaneous grant of id 2 and release of id 0.
        drive(1'b1, 1'b1, 2'd0, 1'b0);
        expect_next("alloc_and_free", 0, mk(1, 2'd0, 4'b0110, 3'd2, 0));

        drive(1'b0, 1'b0, 2'd0, 1'b1);
        expect_next("flush_plain", 0, mk(1, 2'd0, 4'b0000, 3'd0, 0));

        drive(1'b1, 1'b0, 2'd0, 1'b0);
        expect_next("alloc_one", 0, mk(1, 2'd1, 4'b0001, 3'd1, 0));

        // Illegal release: state held, one-cycle error pulse.
        drive(1'b0, 1'b1, 2'd3, 1'b0);
        expect_next("illegal_free_err", 0, mk(1, 2'd1, 4'b0001, 3'd1, 1));
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        expect_next("illegal_free_clear", 0, mk(1, 2'd1, 4'b0001, 3'd1, 0));

        drive(1'b1, 1'b0, 2'd0, 1'b0);
        expect_next("refill_1", 0, mk(1, 2'd2, 4'b0011, 3'd2, 0));
        expect_next("refill_2", 0, mk(1, 2'd3, 4'b0111, 3'd3, 0));

        // Flush beats a concurrent grant of id 3 and release of id 1.
        drive(1'b1, 1'b1, 2'd1, 1'b1);
        expect_next("flush_priority", 0, mk(1, 2'd0, 4'b0000, 3'd0, 0));

        // Releasing from empty is illegal and must not wrap the count.
        drive(1'b0, 1'b1, 2'd0, 1'b0);
        expect_next("free_when_empty", 0, mk(1, 2'd0, 4'b0000, 3'd0, 1));

        // Build state with a pending error pulse, then reset between edges.
        drive(1'b1, 1'b1, 2'd2, 1'b0);
        expect_next("pre_reset_lsb", 0, mk(1, 2'd1, 4'b0001, 3'd1, 1));
        expect_now("pre_reset_msb", 1, mk(1, 2'd2, 4'b1000, 3'd1, 1));
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        arst = 1'b1;
        #1;
        expect_now("midreset_lsb", 0, mk(1, 2'd0, 4'b0000, 3'd0, 0));
        expect_now("midreset_msb", 1, mk(1, 2'd3, 4'b0000, 3'd0, 0));
        #2;
        arst = 1'b0;
        #1;
        expect_now("after_reset_msb", 1, mk(1, 2'd3, 4'b0000, 3'd0, 0));

        drive(1'b1, 1'b0, 2'd0, 1'b0);
        expect_next("msb_alloc_3", 1, mk(1, 2'd2, 4'b1000, 3'd1, 0));
        expect_next("msb_alloc_2", 1, mk(1, 2'd1, 4'b1100, 3'd2, 0));
        drive(1'b0, 1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slot_alloc.md
SLOT_ALLOC -- requirements
Module: slot_alloc

Interface
REQ-001 SHALL have parameter W, default 16, meaning number of allocatable slots (W >= 2).
REQ-002 SHALL have parameter FROM_LSB, default 1, meaning that when 1 the lowest-index free slot is offered first, and when 0 the highest-index free slot is offered first.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port arst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port o_alloc_vld  output  1  a free slot is being offered.
REQ-006 SHALL have port o_alloc_id  output  $clog2(W)  index of the offered slot.
REQ-007 SHALL have port i_alloc_rdy  input  1  requester accepts the offered slot.
REQ-008 SHALL have port i_free_vld  input  1  release request.
REQ-009 SHALL have port i_free_id  input  $clog2(W)  index of the slot to release.
REQ-010 SHALL have port i_flush  input  1  release all slots.
REQ-011 SHALL have port o_busy  output  W  per-slot busy vector (1 = allocated).
REQ-012 SHALL have port o_cnt  output  $clog2(W+1)  number of busy slots.
REQ-013 SHALL have port o_full  output  1  all slots busy.
REQ-014 SHALL have port o_empty  output  1  no slots busy.
REQ-015 SHALL have port o_free_err  output  1  registered one-cycle pulse flagging an illegal release.

Function
REQ-016 SHALL hold state in registers only: busy vector busy_r[W-1:0], count cnt_r, and free-error flag err_r.
REQ-017 SHALL select the offered slot by applying the codebase leading-zero detector (DETECT_ZERO=1, FROM_LSB per parameter) to busy_r, then encoding the resulting one-hot vector to an index.
REQ-018 SHALL drive o_alloc_vld = ~&busy_r combinationally from state; o_alloc_id SHALL be the selected index, and SHALL be 0 when o_alloc_vld=0.
REQ-019 SHALL make o_alloc_vld/o_alloc_id independent of i_alloc_rdy, i_free_*, and i_flush (no combinational input-to-output path).
REQ-020 SHALL treat an allocation as accepted when o_alloc_vld & i_alloc_rdy; on acceptance, busy_r[o_alloc_id] SHALL be 1 on the next cycle.
REQ-021 SHALL ignore i_alloc_rdy when o_alloc_vld=0; state SHALL be unchanged.
REQ-022 SHALL treat a release as legal when i_free_vld=1 and busy_r[i_free_id]=1; a legal release SHALL clear that bit on the next cycle.
REQ-023 SHALL treat a release as illegal when i_free_vld=1 and either busy_r[i_free_id]=0 or i_free_id>=W.
REQ-024 SHALL leave state unchanged on an illegal release, and SHALL assert o_free_err for exactly the following cycle.
REQ-025 SHALL never offer a slot freed in cycle N before cycle N+1 (no free-to-alloc bypass).
REQ-026 SHALL apply a simultaneous accepted allocation and legal release (necessarily different slots) in the same cycle, with cnt_r unchanged.
REQ-027 SHALL update cnt_r as +1 for an accepted allocation, -1 for a legal release, and 0 net when both occur.
REQ-028 SHALL ensure cnt_r never wraps; cnt_r SHALL always equal popcount(busy_r).
REQ-029 SHALL give i_flush priority over allocation and release in the same cycle: next-cycle busy_r=0 and cnt_r=0, the concurrent acceptance is discarded, and o_free_err is not raised for a concurrent release.
REQ-030 SHALL drive o_full = (cnt_r==W) and o_empty = (cnt_r==0) from registers/state, and o_busy = busy_r.

Reset
REQ-031 SHALL, while arst=1 (asynchronously), set busy_r=0, cnt_r=0, and err_r=0.
REQ-032 SHALL therefore drive during and after reset: o_alloc_vld=1, o_alloc_id=0 (FROM_LSB=1) or W-1 (FROM_LSB=0), o_busy=0, o_cnt=0, o_full=0, o_empty=1, o_free_err=0.
REQ-033 SHALL, on reset asserted mid-operation, discard all allocations, with no pending error pulse surviving reset.

Verification
REQ-034 SHALL cover fill (W=4, FROM_LSB=1): i_alloc_rdy=1 for 5 cycles -> ids 0,1,2,3 granted; then o_alloc_vld=0, o_full=1, o_cnt=4, and the 5th cycle has no state change.
REQ-035 SHALL cover release and reuse: from full, free id 2 -> next cycle o_alloc_vld=1, o_alloc_id=2, o_cnt=3; in the free cycle itself o_alloc_vld stays 0.
REQ-036 SHALL cover simultaneous operations: busy=4'b0011, accept (id 2) and free id 0 in the same cycle -> busy=4'b0110, o_cnt=2, next offer id 0.
REQ-037 SHALL cover illegal release: busy=4'b0001, free id 3 -> busy unchanged, o_free_err=1 for one cycle, then 0.
REQ-038 SHALL cover flush priority: busy=4'b0111, i_flush with accept of id 3 and free of id 1 -> next cycle busy=0, o_empty=1, o_free_err=0.
REQ-039 SHALL cover FROM_LSB=0 with async reset mid-operation: after reset, allocating 2 slots gives ids 3 then 2; arst pulsed between clock edges -> outputs return immediately to REQ-032 values.
